// File: rtl/data_mem_pkg.sv
// Shared definitions for the RV32 load/store unit: funct3 codes, the in-flight
// request metadata, and the byte-lane helpers used on the store and load paths.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef struct packed {
    logic       vld;
    logic       is_load;
    logic [2:0] funct3;
    logic [1:0] off;
    logic       err;
  } lsu_meta_t;

  function automatic logic [3:0] be_from_size(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = 4'b0011 << off;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Narrow store data is replicated so the byte enables alone pick the lane.
  function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [2:0] funct3);
    logic [31:0] lanes;
    case (funct3[1:0])
      2'd0:    lanes = {4{wdata[7:0]}};
      2'd1:    lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] funct3,
                                              input logic [1:0] off);
    logic [31:0] lane;
    logic [31:0] res;
    lane = word >> {off, 3'b000};
    case (funct3)
      F3_B:    res = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   res = {24'd0, lane[7:0]};
      F3_H:    res = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   res = {16'd0, lane[15:0]};
      F3_W:    res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  function automatic logic access_err(input logic is_store, input logic [2:0] funct3,
                                      input logic [1:0] off, input logic oor);
    logic bad_f3;
    logic misal;
    if (is_store) bad_f3 = (funct3 > F3_W);
    else          bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    case (funct3)
      F3_H, F3_HU: misal = off[0];
      F3_W:        misal = |off;
      default:     misal = 1'b0;
    endcase
    return oor | bad_f3 | misal;
  endfunction

endpackage

// File: rtl/data_mem_lsu_ram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables and a
// registered read port that holds its value while the read enable is low.
module ram_sp_be
  import data_mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 4096,
  parameter string INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_lsu.sv
// RV32 load/store unit in front of a byte-enable RAM: validates each access,
// writes stores at acceptance, and returns one in-order response per request.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 4096,
  parameter int    READ_LAT    = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic          stall;
  logic          req_fire;
  logic          req_err;
  logic          addr_oor;
  logic [1:0]    req_off;
  logic [AW-1:0] req_idx;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [31:0]   last_word;
  lsu_meta_t     meta_d [READ_LAT];
  lsu_meta_t     meta_q [READ_LAT];
  lsu_meta_t     meta_last;

  assign meta_last  = meta_q[READ_LAT-1];
  assign resp_valid = meta_last.vld;
  assign stall      = resp_valid & ~resp_ready;
  assign req_ready  = ~stall & rst_n;
  assign req_fire   = req_valid & req_ready;

  assign req_off  = req_addr[1:0];
  assign req_idx  = req_addr[AW+1:2];
  assign addr_oor = (req_addr >> (AW + 2)) != 32'd0;
  assign req_err  = access_err(req_we, req_funct3, req_off, addr_oor);

  // Writes commit at acceptance so any later load sees them regardless of latency.
  assign ram_we    = (req_fire & req_we & ~req_err) ? be_from_size(req_funct3, req_off) : 4'b0000;
  assign ram_wdata = store_lanes(req_wdata, req_funct3);

  ram_sp_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (~stall),
    .we    (ram_we),
    .addr  (req_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    for (int i = 0; i < READ_LAT; i++) meta_d[i] = meta_q[i];
    if (!stall) begin
      meta_d[0] = '{vld: req_fire, is_load: ~req_we, funct3: req_funct3, off: req_off, err: req_err};
      for (int i = 1; i < READ_LAT; i++) meta_d[i] = meta_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) meta_q[i] <= '0;
    end else begin
      for (int i = 0; i < READ_LAT; i++) meta_q[i] <= meta_d[i];
    end
  end

  // Stage p0 is the RAM output register; extra stages carry the raw word.
  generate
    if (READ_LAT > 1) begin : g_word_pipe
      logic [31:0] word_d [READ_LAT-1];
      logic [31:0] word_q [READ_LAT-1];

      always_comb begin
        for (int i = 0; i < READ_LAT - 1; i++) word_d[i] = word_q[i];
        if (!stall) begin
          word_d[0] = ram_rdata;
          for (int i = 1; i < READ_LAT - 1; i++) word_d[i] = word_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        for (int i = 0; i < READ_LAT - 1; i++) word_q[i] <= word_d[i];
      end

      assign last_word = word_q[READ_LAT-2];
    end else begin : g_no_pipe
      assign last_word = ram_rdata;
    end
  endgenerate

  assign resp_rdata = (meta_last.vld & meta_last.is_load & ~meta_last.err)
                      ? load_extend(last_word, meta_last.funct3, meta_last.off) : 32'd0;
  assign resp_err   = meta_last.vld & meta_last.err;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: a byte-array reference memory predicts every
// response; monitors pop and compare as the DUTs present responses.
module tb_data_mem_lsu;

  localparam int DEPTH = 64;
  localparam int RL    = 3;
  localparam int RL1   = 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    logic        chk_lat;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        resp_ready = 1'b1;
  logic        dual = 1'b1;
  logic        req_valid1, req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nops = 0;
  int   mode = 0;
  exp_t q[$];
  exp_t q1[$];
  logic [7:0] mem_m [4*DEPTH];

  assign req_valid1 = req_valid & dual;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .READ_LAT(RL), .INIT_FILE("")) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .READ_LAT(RL1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_ready(1'b1), .resp_rdata(resp_rdata1), .resp_err(resp_err1));

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s op%0d: got %h, expected %h", name, id, act, exp);
    end
  endtask

  // Reference model: plain byte-addressed memory and the access rules.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if (addr >= 32'(4*DEPTH)) return 1'b1;
    if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
    if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if ((addr & 32'(size_of(f3) - 1)) != 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    longint v = 0;
    int     sz = size_of(f3);
    for (int k = 0; k < sz; k++) v = v + (longint'(mem_m[int'(addr) + k]) << (8*k));
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (64'sd1 << (8*sz - 1))) v = v - (64'sd1 << (8*sz));
    return 32'(v);
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    for (int k = 0; k < size_of(f3); k++) mem_m[int'(addr) + k] = 8'(wd >> (8*k));
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   w = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    while (!(req_ready && (!dual || req_ready1))) begin
      if (w > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout op%0d: req_ready stayed %b, expected 1", nops, req_ready);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk); #1; w++;
    end
    e.err     = model_err(we, f3, addr);
    e.rdata   = (we || e.err) ? 32'd0 : model_load(f3, addr);
    e.cyc     = cyc;
    e.chk_lat = (mode == 0);
    e.id      = nops;
    if (we && !e.err) model_store(f3, addr, wd);
    q.push_back(e);
    if (dual) begin
      e.chk_lat = 1'b1;
      q1.push_back(e);
    end
    nops++;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || q1.size() != 0) && w < 1000) begin
      @(negedge clk); w++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: pending responses %0d/%0d, expected 0/0", q.size(), q1.size());
    end
  endtask

  initial begin : mon
    int          k = 0;
    logic        pstall = 1'b0;
    logic [31:0] prd = 32'd0;
    logic        perr = 1'b0;
    logic [3:0]  pat = 4'b1001;
    exp_t        e;
    forever begin
      @(negedge clk);
      case (mode)
        0:       begin resp_ready = 1'b1; k = 0; end
        1:       begin resp_ready = pat[k % 4]; k++; end
        default: begin resp_ready = ($urandom_range(0, 3) != 0); k = 0; end
      endcase
      #1;
      if (!rst_n) begin
        pstall = 1'b0;
        continue;
      end
      if (pstall) begin
        chk("hold_valid", -1, 32'(resp_valid), 32'd1);
        chk("hold_rdata", -1, resp_rdata, prd);
        chk("hold_err", -1, 32'(resp_err), 32'(perr));
      end
      chk("req_ready", -1, 32'(req_ready), 32'(!(resp_valid && !resp_ready)));
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_resp: got rdata %h err %b, expected no response", resp_rdata, resp_err);
        end else begin
          e = q.pop_front();
          chk("rdata", e.id, resp_rdata, e.rdata);
          chk("err", e.id, 32'(resp_err), 32'(e.err));
          if (e.chk_lat) chk("latency", e.id, 32'(cyc - e.cyc), 32'(RL));
        end
      end
      pstall = resp_valid && !resp_ready;
      prd    = resp_rdata;
      perr   = resp_err;
    end
  end

  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && resp_valid1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_resp1: got rdata %h err %b, expected no response", resp_rdata1, resp_err1);
        end else begin
          e = q1.pop_front();
          chk("rdata_rl1", e.id, resp_rdata1, e.rdata);
          chk("err_rl1", e.id, 32'(resp_err1), 32'(e.err));
          chk("latency_rl1", e.id, 32'(cyc - e.cyc), 32'(RL1));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    for (int i = 0; i < 4*DEPTH; i++) mem_m[i] = 8'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_resp_valid", 0, 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 0, resp_rdata, 32'd0);
    chk("rst_resp_err", 0, 32'(resp_err), 32'd0);
    chk("rst_req_ready", 0, 32'(req_ready), 32'd0);
    chk("rst_req_ready1", 0, 32'(req_ready1), 32'd0);
    chk("rst_resp_valid1", 0, 32'(resp_valid1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mode = 0; dual = 1'b1;
    for (int w = 0; w < DEPTH; w++) issue(1'b1, 3'd2, 32'(w*4), 32'd0);
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 3'd2, 32'h10, 32'd0);
    issue(1'b1, 3'd0, 32'h21, 32'hABCD1280);
    issue(1'b0, 3'd0, 32'h21, 32'd0);
    issue(1'b0, 3'd4, 32'h21, 32'd0);
    issue(1'b0, 3'd2, 32'h20, 32'd0);
    issue(1'b1, 3'd2, 32'h30, 32'h11223344);
    issue(1'b1, 3'd1, 32'h33, 32'h1234);
    issue(1'b0, 3'd2, 32'h30, 32'd0);
    issue(1'b0, 3'd2, 32'h02, 32'd0);
    issue(1'b0, 3'd3, 32'h00, 32'd0);
    issue(1'b0, 3'd2, 32'(4*DEPTH), 32'd0);
    issue(1'b1, 3'd1, 32'h26, 32'h5555F00D);
    issue(1'b0, 3'd1, 32'h26, 32'd0);
    issue(1'b0, 3'd5, 32'h26, 32'd0);
    issue(1'b0, 3'd1, 32'h24, 32'd0);
    issue(1'b1, 3'd2, 32'h50, 32'hCAFEF00D);
    issue(1'b0, 3'd2, 32'h50, 32'd0);
    drain();
    dual = 1'b0;

    mode = 1;
    for (int n = 0; n < 8; n++) issue(1'b0, 3'd2, 32'($urandom_range(0, DEPTH-1) * 4), 32'd0);
    drain();

    mode = 2;
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      a = 32'($urandom_range(0, 4*DEPTH-1));
      if ($urandom_range(0, 4) != 0) a = a & ~32'(size_of(f3) - 1);
      if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(8, 31));
      issue(we, f3, a, $urandom());
      if ($urandom_range(0, 4) == 0) @(posedge clk);
    end
    drain();

    mode = 0;
    repeat (2) @(negedge clk);
    issue(1'b1, 3'd2, 32'h40, 32'h13579BDF);
    issue(1'b0, 3'd2, 32'h40, 32'd0);
    issue(1'b0, 3'd2, 32'h44, 32'd0);
    issue(1'b1, 3'd2, 32'h48, 32'h2468ACE0);
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", nops, 32'(resp_valid), 32'd0);
    chk("midrst_req_ready", nops, 32'(req_ready), 32'd0);
    chk("midrst_resp_rdata", nops, resp_rdata, 32'd0);
    q.delete();
    q1.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(1'b0, 3'd2, 32'h40, 32'd0);
    issue(1'b0, 3'd2, 32'h48, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
